pifo_calendar_cpu_master: RTL and testbench

Initiator for the CPU access channel of the PIFO calendar. It accepts single read, single write and range-scan requests on a valid/ready request port. It drives the calendar's cpu_rd_*/cpu_wr_* pulses, waits for each result with a timeout, and returns one response per access on a valid/ready response port. It sits between the control-plane register interface and the calendar.

---
 rtl/pifo_calendar_cpu_master_if.sv | 53 +++++
 rtl/pifo_calendar_cpu_master.sv | 150 +++++++++++++++
 tb/tb_pifo_calendar_cpu_master.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pifo_calendar_cpu_master_if.sv
// Bundles for the CPU access path of the PIFO calendar: the control-plane
// request/response channel and the calendar's cpu_rd_*/cpu_wr_* channel.
interface pifo_calendar_cpu_master_if #(
  parameter int INDEX_WIDTH = 9,
  parameter int ROOT_WIDTH  = 32
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic                   req_scan;
  logic [INDEX_WIDTH-1:0] req_addr;
  logic [ROOT_WIDTH-1:0]  req_wdata;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [INDEX_WIDTH-1:0] resp_addr;
  logic [ROOT_WIDTH-1:0]  resp_data;
  logic                   resp_error;
  logic                   resp_last;

  // master = control plane issuing requests, slave = the access engine
  modport master (
    output req_valid, req_write, req_scan, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_addr, resp_data, resp_error, resp_last
  );
  modport slave (
    input  req_valid, req_write, req_scan, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_addr, resp_data, resp_error, resp_last
  );
endinterface

interface pifo_calendar_cpu_master_cal_if #(
  parameter int INDEX_WIDTH = 9,
  parameter int ROOT_WIDTH  = 32
);
  logic                   cpu_rd_valid;
  logic [INDEX_WIDTH-1:0] cpu_rd_addr;
  logic                   cpu_rd_result_valid;
  logic [ROOT_WIDTH-1:0]  cpu_rd_result;
  logic                   cpu_wr_valid;
  logic [INDEX_WIDTH-1:0] cpu_wr_addr;
  logic [ROOT_WIDTH-1:0]  cpu_wr_data;
  logic                   cpu_wr_result_valid;

  // master = access engine, slave = calendar
  modport master (
    output cpu_rd_valid, cpu_rd_addr, cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
    input  cpu_rd_result_valid, cpu_rd_result, cpu_wr_result_valid
  );
  modport slave (
    input  cpu_rd_valid, cpu_rd_addr, cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
    output cpu_rd_result_valid, cpu_rd_result, cpu_wr_result_valid
  );
endinterface

// File: rtl/pifo_calendar_cpu_master.sv
// CPU access initiator for the PIFO calendar: single read/write and range scan,
// one outstanding calendar access, per-access timeout, registered outputs.
module pifo_calendar_cpu_master #(
  parameter int PIFO_CALENDAR_SIZE        = 512,
  parameter int PIFO_CALENDAR_INDEX_WIDTH = 9,
  parameter int PIFO_ROOT_WIDTH           = 32,
  parameter int TIMEOUT_CYCLES            = 1024,
  parameter int TIMEOUT_WIDTH             = 11
) (
  input  logic                          clk,
  input  logic                          rstn,
  pifo_calendar_cpu_master_if.slave     req,
  pifo_calendar_cpu_master_cal_if.master cal,
  output logic                          busy
);
  localparam int IW = PIFO_CALENDAR_INDEX_WIDTH;
  localparam int RW = PIFO_ROOT_WIDTH;
  localparam int TW = TIMEOUT_WIDTH;
  localparam logic [IW:0]   SIZE_X    = (IW+1)'(PIFO_CALENDAR_SIZE);
  localparam logic [IW-1:0] LAST_ADDR = IW'(PIFO_CALENDAR_SIZE - 1);
  localparam logic [TW-1:0] TMO_LIM   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic            is_write, is_scan;
  logic [IW-1:0]   addr_q;
  logic [TW-1:0]   tmo_cnt;
  logic            hit;

  logic            req_ready_q, resp_valid_q, resp_error_q, resp_last_q, busy_q;
  logic [IW-1:0]   resp_addr_q;
  logic [RW-1:0]   resp_data_q;
  logic            rd_valid_q, wr_valid_q;
  logic [IW-1:0]   rd_addr_q, wr_addr_q;
  logic [RW-1:0]   wr_data_q;

  // only the strobe matching the pending access type completes it
  assign hit = is_write ? cal.cpu_wr_result_valid : cal.cpu_rd_result_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      is_write     <= 1'b0;
      is_scan      <= 1'b0;
      addr_q       <= '0;
      tmo_cnt      <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_addr_q  <= '0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_addr_q    <= '0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            is_write    <= req.req_write;
            is_scan     <= req.req_scan & ~req.req_write;
            addr_q      <= req.req_addr;
            if ({1'b0, req.req_addr} >= SIZE_X) begin
              resp_valid_q <= 1'b1;
              resp_addr_q  <= req.req_addr;
              resp_data_q  <= '0;
              resp_error_q <= 1'b1;
              resp_last_q  <= 1'b1;
              state        <= RESP;
            end else begin
              // the access pulse is launched here so it is visible during ISSUE
              if (req.req_write) begin
                wr_valid_q <= 1'b1;
                wr_addr_q  <= req.req_addr;
                wr_data_q  <= req.req_wdata;
              end else begin
                rd_valid_q <= 1'b1;
                rd_addr_q  <= req.req_addr;
              end
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          rd_valid_q <= 1'b0;
          wr_valid_q <= 1'b0;
          tmo_cnt    <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (hit) begin
            resp_valid_q <= 1'b1;
            resp_addr_q  <= addr_q;
            resp_data_q  <= is_write ? '0 : cal.cpu_rd_result;
            resp_error_q <= 1'b0;
            resp_last_q  <= !is_scan || (addr_q == LAST_ADDR);
            state        <= RESP;
          end else if (tmo_cnt == TMO_LIM) begin
            resp_valid_q <= 1'b1;
            resp_addr_q  <= addr_q;
            resp_data_q  <= '0;
            resp_error_q <= 1'b1;
            resp_last_q  <= 1'b1;
            state        <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          if (req.resp_ready) begin
            resp_valid_q <= 1'b0;
            // scan advances only after the consumer takes the previous entry
            if (is_scan && !resp_error_q && (addr_q != LAST_ADDR)) begin
              addr_q     <= addr_q + 1'b1;
              rd_valid_q <= 1'b1;
              rd_addr_q  <= addr_q + 1'b1;
              state      <= ISSUE;
            end else begin
              is_scan     <= 1'b0;
              busy_q      <= 1'b0;
              req_ready_q <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req.req_ready   = req_ready_q;
  assign req.resp_valid  = resp_valid_q;
  assign req.resp_addr   = resp_addr_q;
  assign req.resp_data   = resp_data_q;
  assign req.resp_error  = resp_error_q;
  assign req.resp_last   = resp_last_q;
  assign cal.cpu_rd_valid = rd_valid_q;
  assign cal.cpu_rd_addr  = rd_addr_q;
  assign cal.cpu_wr_valid = wr_valid_q;
  assign cal.cpu_wr_addr  = wr_addr_q;
  assign cal.cpu_wr_data  = wr_data_q;
  assign busy             = busy_q;
endmodule

// File: tb/tb_pifo_calendar_cpu_master.sv
// Scoreboard bench: calendar model plus response consumer in one negedge BFM;
// expected responses and calendar accesses are queued as stimulus is driven.
module tb_pifo_calendar_cpu_master;
  localparam int SIZE = 512, IW = 10, RW = 32, TMO = 1024, TW = 11;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  pifo_calendar_cpu_master_if     #(.INDEX_WIDTH(IW), .ROOT_WIDTH(RW)) rq();
  pifo_calendar_cpu_master_cal_if #(.INDEX_WIDTH(IW), .ROOT_WIDTH(RW)) cl();

  pifo_calendar_cpu_master #(
    .PIFO_CALENDAR_SIZE(SIZE), .PIFO_CALENDAR_INDEX_WIDTH(IW),
    .PIFO_ROOT_WIDTH(RW), .TIMEOUT_CYCLES(TMO), .TIMEOUT_WIDTH(TW)
  ) dut (.clk(clk), .rstn(rstn), .req(rq), .cal(cl), .busy(busy));

  typedef struct {
    logic [IW-1:0] addr;
    logic [RW-1:0] data;
    logic          err;
    logic          last;
  } rsp_t;

  rsp_t             exp_q[$];
  logic [IW-1:0]    exp_rd_q[$];
  logic [IW+RW-1:0] exp_wr_q[$];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [RW-1:0] cal_data(input logic [IW-1:0] a);
    return (a == 10'd5) ? 32'h8000_1234 : {16'hA5A5, 6'd0, a};
  endfunction

  task automatic exp_rsp(input logic [IW-1:0] a, input logic [RW-1:0] d,
                         input logic e, input logic l);
    rsp_t r;
    r.addr = a; r.data = d; r.err = e; r.last = l;
    exp_q.push_back(r);
  endtask

  // calendar model / consumer controls (rd_lat 0 = never answer)
  int   rd_lat = 1, wr_lat = 1, rd_cnt = 0, wr_cnt = 0, bp_cnt = 0;
  int   rd_pulses = 0, wr_pulses = 0;
  bit   bp_mode = 0, stray = 0, outstanding = 0, hold = 0;
  logic [IW-1:0] rd_a;
  rsp_t prev;

  always @(negedge clk) begin
    cl.cpu_rd_result_valid = 1'b0;
    cl.cpu_wr_result_valid = 1'b0;
    cl.cpu_rd_result       = '0;
    if (!rstn) begin
      rd_cnt = 0; wr_cnt = 0; bp_cnt = 0; outstanding = 0; hold = 0;
      rq.resp_ready = 1'b0;
    end else begin
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          cl.cpu_rd_result_valid = 1'b1;
          cl.cpu_rd_result       = cal_data(rd_a);
        end
      end
      if (wr_cnt > 0) begin
        wr_cnt--;
        if (wr_cnt == 0) cl.cpu_wr_result_valid = 1'b1;
      end
      if (stray) begin
        cl.cpu_rd_result_valid = 1'b1;
        cl.cpu_rd_result       = 32'hDEAD_BEEF;
        cl.cpu_wr_result_valid = 1'b1;
        stray = 0;
      end
      if (cl.cpu_rd_valid) begin
        rd_pulses++;
        chk("rd_overlap", 64'(outstanding), 64'd0);
        outstanding = 1;
        if (exp_rd_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
        else chk("rd_addr", 64'(cl.cpu_rd_addr), 64'(exp_rd_q.pop_front()));
        rd_a   = cl.cpu_rd_addr;
        rd_cnt = rd_lat;
      end
      if (cl.cpu_wr_valid) begin
        wr_pulses++;
        chk("wr_overlap", 64'(outstanding), 64'd0);
        outstanding = 1;
        if (exp_wr_q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
        else chk("wr_addr_data", 64'({cl.cpu_wr_addr, cl.cpu_wr_data}), 64'(exp_wr_q.pop_front()));
        wr_cnt = wr_lat;
      end
      // consumer: under backpressure hold ready low for 4 cycles per response
      if (bp_mode) begin
        if (rq.resp_valid && bp_cnt == 4) begin rq.resp_ready = 1'b1; bp_cnt = 0; end
        else if (rq.resp_valid) begin rq.resp_ready = 1'b0; bp_cnt++; end
        else begin rq.resp_ready = 1'b0; bp_cnt = 0; end
      end else begin
        rq.resp_ready = 1'b1;
      end
      if (hold) begin
        chk("hold_valid", 64'(rq.resp_valid), 64'd1);
        chk("hold_fields", 64'({rq.resp_addr, rq.resp_data, rq.resp_error, rq.resp_last}),
            64'({prev.addr, prev.data, prev.err, prev.last}));
      end
      if (rq.resp_valid && rq.resp_ready) begin
        outstanding = 0;
        if (exp_q.size() == 0) chk("resp_unexpected", 64'd1, 64'd0);
        else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("resp_addr",  64'(rq.resp_addr),  64'(e.addr));
          chk("resp_data",  64'(rq.resp_data),  64'(e.data));
          chk("resp_error", 64'(rq.resp_error), 64'(e.err));
          chk("resp_last",  64'(rq.resp_last),  64'(e.last));
        end
      end
      hold = rq.resp_valid && !rq.resp_ready;
      prev.addr = rq.resp_addr; prev.data = rq.resp_data;
      prev.err  = rq.resp_error; prev.last = rq.resp_last;
    end
  end

  task automatic drive_req(input bit w, input bit s, input logic [IW-1:0] a,
                           input logic [RW-1:0] d);
    int n = 0;
    @(negedge clk);
    while (!rq.req_ready && n < 2000) begin @(negedge clk); n++; end
    if (!rq.req_ready) chk("req_ready_timeout", 64'd0, 64'd1);
    rq.req_valid = 1'b1; rq.req_write = w; rq.req_scan = s;
    rq.req_addr = a; rq.req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    rq.req_valid = 1'b0;
  endtask

  // cycles from the request handshake edge until resp_valid is seen
  task automatic send(input bit w, input bit s, input logic [IW-1:0] a,
                      input logic [RW-1:0] d, output int lat);
    drive_req(w, s, a, d);
    lat = 1;
    while (!rq.resp_valid && lat < 3000) begin @(negedge clk); lat++; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || rq.resp_valid || exp_q.size() != 0) && n < 5000) begin
      @(negedge clk); n++;
    end
    if (n >= 5000) chk("idle_timeout", 64'd0, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [63:0] outs_or();
    return 64'({rq.req_ready, rq.resp_valid, rq.resp_error, rq.resp_last, busy,
                cl.cpu_rd_valid, cl.cpu_wr_valid} != 0) |
           64'({rq.resp_addr, cl.cpu_rd_addr, cl.cpu_wr_addr} != 0) |
           64'({rq.resp_data, cl.cpu_wr_data} != 0);
  endfunction

  initial begin
    int lat, p_rd, p_wr;
    rq.req_valid = 1'b0; rq.req_write = 1'b0; rq.req_scan = 1'b0;
    rq.req_addr = '0; rq.req_wdata = '0; rq.resp_ready = 1'b0;
    cl.cpu_rd_result_valid = 1'b0; cl.cpu_wr_result_valid = 1'b0; cl.cpu_rd_result = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_or(), 64'd0);
    rstn = 1'b1;

    // single read, answer one cycle after the pulse
    p_rd = rd_pulses; p_wr = wr_pulses; rd_lat = 1;
    exp_rd_q.push_back(10'd5); exp_rsp(10'd5, 32'h8000_1234, 1'b0, 1'b1);
    send(1'b0, 1'b0, 10'd5, '0, lat);
    chk("rd_latency", 64'(lat), 64'd3);
    wait_idle();
    chk("rd_pulse_count", 64'(rd_pulses - p_rd), 64'd1);
    chk("rd_no_write", 64'(wr_pulses - p_wr), 64'd0);

    // write with completion delayed 20 cycles
    p_rd = rd_pulses; p_wr = wr_pulses; wr_lat = 20;
    exp_wr_q.push_back({10'd3, 32'hC000_0042}); exp_rsp(10'd3, '0, 1'b0, 1'b1);
    send(1'b1, 1'b0, 10'd3, 32'hC000_0042, lat);
    chk("wr_latency", 64'(lat), 64'd22);
    wait_idle();
    chk("wr_pulse_count", 64'(wr_pulses - p_wr), 64'd1);
    chk("wr_no_read", 64'(rd_pulses - p_rd), 64'd0);

    // strobe on the final WAIT cycle still succeeds
    rd_lat = TMO;
    exp_rd_q.push_back(10'd6); exp_rsp(10'd6, cal_data(10'd6), 1'b0, 1'b1);
    send(1'b0, 1'b0, 10'd6, '0, lat);
    chk("edge_latency", 64'(lat), 64'(TMO + 2));
    wait_idle();

    // one cycle too late: timeout error, late strobe ignored
    rd_lat = TMO + 1;
    exp_rd_q.push_back(10'd7); exp_rsp(10'd7, '0, 1'b1, 1'b1);
    send(1'b0, 1'b0, 10'd7, '0, lat);
    chk("tmo_latency", 64'(lat), 64'(TMO + 2));
    wait_idle();
    stray = 1;
    repeat (4) @(negedge clk);
    chk("stray_busy", 64'(busy), 64'd0);
    chk("stray_resp", 64'(rq.resp_valid), 64'd0);
    chk("stray_ready", 64'(rq.req_ready), 64'd1);

    // scan 509..511 under backpressure
    p_rd = rd_pulses; rd_lat = 1; bp_mode = 1;
    for (int a = 509; a < SIZE; a++) begin
      exp_rd_q.push_back(IW'(a));
      exp_rsp(IW'(a), cal_data(IW'(a)), 1'b0, (a == SIZE - 1));
    end
    send(1'b0, 1'b1, 10'd509, '0, lat);
    chk("scan_first_latency", 64'(lat), 64'd3);
    wait_idle();
    bp_mode = 0;
    chk("scan_pulse_count", 64'(rd_pulses - p_rd), 64'd3);

    // write+scan behaves as a single write
    p_rd = rd_pulses; p_wr = wr_pulses; wr_lat = 2;
    exp_wr_q.push_back({10'd510, 32'h1234_5678}); exp_rsp(10'd510, '0, 1'b0, 1'b1);
    send(1'b1, 1'b1, 10'd510, 32'h1234_5678, lat);
    wait_idle();
    chk("wrscan_wr_count", 64'(wr_pulses - p_wr), 64'd1);
    chk("wrscan_rd_count", 64'(rd_pulses - p_rd), 64'd0);

    // out-of-range address: immediate error, no calendar access
    p_rd = rd_pulses; p_wr = wr_pulses;
    exp_rsp(10'd600, '0, 1'b1, 1'b1);
    send(1'b0, 1'b1, 10'd600, '0, lat);
    chk("oor_latency", 64'(lat), 64'd1);
    wait_idle();
    chk("oor_no_access", 64'((rd_pulses - p_rd) + (wr_pulses - p_wr)), 64'd0);

    // reset while waiting aborts the access
    rd_lat = 0;
    exp_rd_q.push_back(10'd9);
    drive_req(1'b0, 1'b0, 10'd9, '0);
    repeat (5) @(negedge clk);
    chk("wait_busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    #1;
    chk("midreset_outputs", outs_or(), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    rd_lat = 1;
    exp_rd_q.push_back(10'd10); exp_rsp(10'd10, cal_data(10'd10), 1'b0, 1'b1);
    send(1'b0, 1'b0, 10'd10, '0, lat);
    chk("post_reset_latency", 64'(lat), 64'd3);
    wait_idle();

    chk("sb_resp_empty", 64'(exp_q.size()), 64'd0);
    chk("sb_rd_empty", 64'(exp_rd_q.size()), 64'd0);
    chk("sb_wr_empty", 64'(exp_wr_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
